instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/ifu_pkg.sv | 28 ++
 rtl/ifu_fifo.sv | 59 +++++
 rtl/instr_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   ifu_state_e   - fetch FSM state encoding
//   fetch_entry_t - one prefetch FIFO entry {pc, instr}
//   PC_INC        - sequential fetch stride
//   ALIGN_MASK    - clears the byte-offset bits of an address
//   align_pc()    - word-aligns an address
package ifu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DISCARD
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_INC     = 32'd4;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: prefetch FIFO of {pc, instr} entries between fetch and decode.
//   clk_i, rst_i  - clock, synchronous active-high reset
//   push_i        - write push_data_i at the tail
//   push_data_i   - entry to write
//   pop_i         - drop the head entry
//   flush_i       - empty the FIFO (wins over push/pop)
//   head_o        - entry at the head (meaningful when count_o != 0)
//   count_o       - number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap on their own.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    // Storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i && !rst_i) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + AW'(1);
            if (pop_i)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_o  = mem[rd_ptr];
    assign count_o = count;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential instruction prefetcher with redirect support.
//   clk_i, rst_i             - clock, synchronous active-high reset
//   imem_req_o/addr_o        - fetch request and word-aligned address
//   imem_gnt_i               - memory accepted the request
//   imem_rvalid_i/rdata_i    - read response (one outstanding at most)
//   instr_valid_o/instr_o/instr_pc_o - FIFO head towards decode
//   instr_ready_i            - decode consumes the head
//   redirect_i/redirect_pc_i - branch/jump redirect, flushes prefetched words
//   stall_cnt_o              - only with IFU_STALL_CNT_EN: saturating count of
//                              cycles decode was ready but nothing was valid
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
`ifdef IFU_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    ifu_state_e    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_addr;   // address of the request in flight, held until its response
    logic          req_q;
    logic          killed;     // a redirect hit while the request awaited grant

    fetch_entry_t  push_data;
    fetch_entry_t  head;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // Only one request is ever outstanding and pushes happen only in WAIT,
    // so count < DEPTH when leaving IDLE reserves the slot for the response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            fetch_pc <= align_pc(RESET_PC);
            req_addr <= '0;
            req_q    <= 1'b0;
            killed   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (redirect_i) begin
                        fetch_pc <= align_pc(redirect_pc_i);
                    end else if (count < DEPTH_C) begin
                        state    <= S_REQ;
                        req_q    <= 1'b1;
                        req_addr <= fetch_pc;
                        killed   <= 1'b0;
                    end
                end
                S_REQ: begin
                    // The address stays on the bus until grant even if redirected.
                    if (redirect_i) begin
                        fetch_pc <= align_pc(redirect_pc_i);
                        killed   <= 1'b1;
                    end
                    if (imem_gnt_i) begin
                        req_q <= 1'b0;
                        if (redirect_i || killed) begin
                            state <= S_DISCARD;
                        end else begin
                            state    <= S_WAIT;
                            fetch_pc <= fetch_pc + PC_INC;
                        end
                    end
                end
                S_WAIT: begin
                    if (redirect_i) begin
                        fetch_pc <= align_pc(redirect_pc_i);
                        state    <= imem_rvalid_i ? S_IDLE : S_DISCARD;
                    end else if (imem_rvalid_i) begin
                        state <= S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (redirect_i) fetch_pc <= align_pc(redirect_pc_i);
                    if (imem_rvalid_i) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = req_addr;

    // Redirect wins over both FIFO ports; the flush clears everything anyway.
    assign push      = (state == S_WAIT) && imem_rvalid_i && !redirect_i;
    assign pop       = instr_valid_o && instr_ready_i && !redirect_i;
    assign push_data = '{pc: req_addr, instr: imem_rdata_i};

    ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (redirect_i),
        .head_o      (head),
        .count_o     (count)
    );

    assign instr_valid_o = (count != '0);
    // Gate with valid so the outputs read zero whenever the FIFO is empty.
    assign instr_o       = instr_valid_o ? head.instr : '0;
    assign instr_pc_o    = instr_valid_o ? head.pc    : '0;

`ifdef IFU_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (instr_ready_i && !instr_valid_o && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
`ifdef IFU_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h100)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
`ifdef IFU_STALL_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;

    // memory model / scoreboard state
    logic [31:0] exp_q[$];      // pcs expected to reach decode, in order
    logic [31:0] gnt_log[$];    // every granted address
    int          gnt_cyc[$];    // cycle number of each grant
    int          gnt_block = 0; // cycles to refuse grant while req is high
    int          rv_lat = 1;
    bit          rv_pending = 0;
    int          rv_cnt = 0;
    logic [31:0] rv_addr = '0;
    bit          rv_kill = 0;
    bit          kill_req = 0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: called at a falling edge, drives inputs for the next rising
    // edge from the memory model, books what that edge will do, then returns
    // at the following falling edge.
    task automatic cyc();
        logic [31:0] e;
        if (instr_valid_o && instr_ready_i && !redirect_i && !rst_i) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected_pc", instr_pc_o, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("pop_pc", instr_pc_o, e);
                check("pop_instr", instr_o, data_of(e));
            end
        end
        imem_gnt_i = 1'b0;
        if (imem_req_o) begin
            if (gnt_block > 0) gnt_block--;
            else imem_gnt_i = 1'b1;
        end
        imem_rvalid_i = 1'b0;
        if (rv_pending) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = data_of(rv_addr);
                rv_pending    = 0;
                if (!rv_kill && !redirect_i && !rst_i) exp_q.push_back(rv_addr);
            end
        end
        if ((redirect_i || rst_i) && rv_pending) rv_kill = 1;
        if (imem_gnt_i && !rst_i) begin
            gnt_log.push_back(imem_addr_o);
            gnt_cyc.push_back(cyc_n);
            rv_pending = 1;
            rv_cnt     = rv_lat;
            rv_addr    = imem_addr_o;
            rv_kill    = kill_req || redirect_i;
            kill_req   = 0;
        end
        if (redirect_i && imem_req_o && !imem_gnt_i) kill_req = 1;
        if (redirect_i || rst_i) exp_q.delete();
        if (rst_i) kill_req = 0;
        @(posedge clk_i);
        cyc_n++;
        @(negedge clk_i);
    endtask

    task automatic wait_grants(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && gnt_log.size() < target; i++) cyc();
        check(tag, gnt_log.size(), target);
    endtask

    int base;

    initial begin
        @(negedge clk_i);
        // reset state
        rst_i = 1'b1;
        cyc();
        cyc();
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", instr_pc_o, 32'd0);
        rst_i = 1'b0;

        // sequential fetch from RESET_PC, 1-cycle memory, decode always ready
        instr_ready_i = 1'b1;
        wait_grants(3, 30, "seq_grants");
        check("seq_addr0", gnt_log[0], 32'h100);
        check("seq_addr1", gnt_log[1], 32'h104);
        check("seq_addr2", gnt_log[2], 32'h108);
        check("seq_throughput", gnt_cyc[2] - gnt_cyc[1], 32'd3);

        // FIFO fills to DEPTH with decode stalled, then resumes in order
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        instr_ready_i = 1'b0;
        base = gnt_log.size();
        for (int i = 0; i < 30; i++) cyc();
        check("full_grants", gnt_log.size() - base, 32'd4);
        check("full_req_low", {31'd0, imem_req_o}, 32'd0);
        check("full_valid", {31'd0, instr_valid_o}, 32'd1);
        check("full_head_pc", instr_pc_o, 32'h100);
        check("full_last_addr", gnt_log[base+3], 32'h10C);
        instr_ready_i = 1'b1;
        wait_grants(base + 8, 60, "resume_grants");
        check("resume_addr", gnt_log[base+4], 32'h110);

        // redirect during WAIT; response arrives two cycles later and is dropped
        rv_lat = 3;
        base = gnt_log.size();
        wait_grants(base + 1, 20, "rd_wait_grant");
        redirect_i = 1'b1;
        redirect_pc_i = 32'h203;
        cyc();
        redirect_i = 1'b0;
        rv_lat = 1;
        check("rd_wait_empty", {31'd0, instr_valid_o}, 32'd0);
        wait_grants(base + 2, 20, "rd_wait_next");
        check("rd_wait_addr", gnt_log[base+1], 32'h200);

        // grant withheld 5 cycles, redirect in the second one
        gnt_block = 5;
        base = gnt_log.size();
        for (int i = 0; i < 20 && !imem_req_o; i++) cyc();
        check("hold_req_seen", {31'd0, imem_req_o}, 32'd1);
        cyc();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h300;
        cyc();
        redirect_i = 1'b0;
        check("hold_req", {31'd0, imem_req_o}, 32'd1);
        check("hold_addr", imem_addr_o, 32'h204);
        wait_grants(base + 1, 20, "hold_grant");
        check("hold_gnt_addr", gnt_log[base], 32'h204);
        wait_grants(base + 2, 20, "hold_next");
        check("hold_new_addr", gnt_log[base+1], 32'h300);

        // redirect to the top of the address space wraps to zero
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        cyc();
        redirect_i = 1'b0;
        base = gnt_log.size();
        wait_grants(base + 2, 30, "wrap_grants");
        check("wrap_addr0", gnt_log[base], 32'hFFFF_FFFC);
        check("wrap_addr1", gnt_log[base+1], 32'h0);

        // reset during WAIT, late response must be ignored
        rv_lat = 2;
        base = gnt_log.size();
        wait_grants(base + 1, 20, "rst_wait_grant");
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        rv_lat = 1;
        cyc();
        check("rst_late_valid", {31'd0, instr_valid_o}, 32'd0);
        wait_grants(base + 2, 20, "rst_refetch");
        check("rst_refetch_addr", gnt_log[base+1], 32'h100);
        for (int i = 0; i < 12; i++) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
